// File: rtl/blake2_pkg.sv
// Shared constants for the BLAKE2 round controller: FSM state encodings,
// block size, round counts for the s/b variants and the offset counter width.
package blake2_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_INIT  = 2'd1;
  localparam logic [1:0] ST_COMP  = 2'd2;
  localparam logic [1:0] ST_FINAL = 2'd3;

  localparam int BLOCK_BYTES = 64;
  localparam int ROUNDS_S    = 10;
  localparam int ROUNDS_B    = 12;
  localparam int T_W         = 64;

endpackage

// File: rtl/blake2_t_counter.sv
// 64-bit BLAKE2 byte offset counter: restarts on a first block, accumulates
// the block byte count on every accepted block, wraps modulo 2^64.
module blake2_t_counter
  import blake2_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           first,
  input  logic [6:0]     bytes,
  output logic [T_W-1:0] t
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      t <= '0;
    end else if (load) begin
      t <= (first ? '0 : t) + T_W'(bytes);
    end
  end

endmodule

// File: rtl/blake2_round_ctrl.sv
// BLAKE2 compression sequencer: init, 2*ROUNDS column/diagonal G steps, finalize.
// Optional protocol checker enabled by defining BLAKE2_PROTO_CHK_EN.
module blake2_round_ctrl
  import blake2_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_S,
  parameter int RND_W  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             block_v_i,
  input  logic             block_first_i,
  input  logic             block_last_i,
  input  logic [6:0]       block_bytes_i,
  output logic             block_ready_o,
  output logic             h_init_o,
  output logic             v_init_o,
  output logic             g_v_o,
  output logic             sel_diag_o,
  output logic [RND_W-1:0] round_o,
  output logic [T_W-1:0]   t_o,
  output logic             f_o,
  output logic             finalize_o,
`ifdef BLAKE2_PROTO_CHK_EN
  output logic             proto_err_o,
`endif
  output logic             digest_v_o
);

  localparam int STEP_W = RND_W + 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(2 * ROUNDS - 1);

  logic [1:0]        state;
  logic [STEP_W-1:0] step;
  logic              first_q;
  logic              last_q;
  logic              f_q;
  logic              accept;

  assign accept = (state == ST_IDLE) && block_v_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      step    <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      f_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (block_v_i) begin
          first_q <= block_first_i;
          last_q  <= block_last_i;
          f_q     <= block_last_i;
          state   <= ST_INIT;
        end
        ST_INIT: begin
          step  <= '0;
          state <= ST_COMP;
        end
        ST_COMP: begin
          step <= step + 1'b1;
          if (step == STEP_LAST) state <= ST_FINAL;
        end
        ST_FINAL: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  blake2_t_counter u_t_counter (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .first (block_first_i),
    .bytes (block_bytes_i),
    .t     (t_o)
  );

  // Strobes decode directly from state so an async reset clears them at once.
  assign block_ready_o = (state == ST_IDLE);
  assign v_init_o      = (state == ST_INIT);
  assign h_init_o      = v_init_o && first_q;
  assign g_v_o         = (state == ST_COMP);
  assign sel_diag_o    = g_v_o && step[0];
  assign round_o       = g_v_o ? step[STEP_W-1:1] : '0;
  assign finalize_o    = (state == ST_FINAL);
  assign digest_v_o    = finalize_o && last_q;
  assign f_o           = f_q;

`ifdef BLAKE2_PROTO_CHK_EN
  logic msg_open_q;
  logic proto_err_q;
  logic proto_viol;

  always_comb begin
    // NOTE: default first so no path through this block infers a latch.
    proto_viol = 1'b0;
    if (block_v_i && !block_ready_o)                      proto_viol = 1'b1;
    if (accept && !block_first_i && !msg_open_q)          proto_viol = 1'b1;
    if (block_v_i && block_bytes_i > 7'(BLOCK_BYTES))     proto_viol = 1'b1;
    if (block_v_i && !block_last_i &&
        block_bytes_i != 7'(BLOCK_BYTES))                 proto_viol = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_open_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (accept && block_first_i) msg_open_q <= 1'b1;
      else if (digest_v_o)         msg_open_q <= 1'b0;
      if (proto_viol)              proto_err_q <= 1'b1;
    end
  end

  assign proto_err_o = proto_err_q;
`endif

endmodule
